// File: rtl/fetch_buffer_pkg.sv
// Shared processor definitions for the fetch stage: default bus widths and
// the fetch-entry record (instruction plus the address it came from).
package fetch_buffer_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 16;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: PC side, instruction-memory side and decode side.
// The master modport is the fetch buffer; the slave modport is its environment.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic [ADDR_W-1:0]  pc_addr;
  logic               branch;
  logic               stall;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               dec_ready;

  modport master (
    input  pc_addr, branch, imem_rdata, dec_ready,
    output stall, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output pc_addr, branch, imem_rdata, dec_ready,
    input  stall, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two circular queue with push/pop/flush and an occupancy count.
// Storage is not reset; only pointers and count are.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full queue and pops from an empty one are ignored; flush wins over both.
  always_comb begin
    do_push  = push && (count_q != FULL_COUNT);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues one memory read per cycle while there is room,
// queues returning words with their address, and flushes everything on a branch.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_buffer_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WIDTH = INSTR_W + ADDR_W;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [WIDTH-1:0]  head;
  logic [CNT_W:0]    occupancy;
  logic              stall;
  logic              req;
  logic              valid;
  logic              push;
  logic              pop;

  // Stall counts the outstanding read as occupied, so the queue can never
  // overflow, and it is built only from flops so branch/dec_ready cannot reach it.
  always_comb begin
    occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    stall      = (occupancy >= DEPTH_V);
    req        = !bus.branch && !stall;
    valid      = (fifo_count != '0);
    push       = inflight_q && !bus.branch;
    pop        = valid && bus.dec_ready && !bus.branch;
    inflight_d = req;
    addr_d     = req ? bus.pc_addr : addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.branch),
    .wdata ({bus.imem_rdata, addr_q}),
    .rdata (head),
    .count (fifo_count)
  );

  assign bus.stall       = stall;
  assign bus.imem_req    = req;
  assign bus.imem_addr   = bus.pc_addr;
  assign bus.instr_valid = valid;
  assign bus.instr       = head[WIDTH-1:ADDR_W];
  assign bus.instr_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios then random branch/dec_ready traffic,
// all compared every cycle against a transaction-level queue model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = ADDR_W_DEF;
  localparam int IW    = INSTR_W_DEF;

  logic clk = 1'b0;
  logic reset;

  fetch_buffer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (AW),
    .INSTR_W (IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  fetch_entry_t    model_q[$];
  logic            pend;
  logic [AW-1:0]   pend_addr;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'h1000 + {6'b0, a};
  endfunction

  // Instruction memory answers one cycle after a request.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 16'hDEAD;
  end

  function automatic logic model_stall();
    return (model_q.size() + int'(pend)) >= DEPTH;
  endfunction

  task automatic resetModel();
    model_q.delete();
    pend      = 1'b0;
    pend_addr = '0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic es;
    es = model_stall();
    checkVal("stall", 32'(bus.stall), 32'(es));
    checkVal("imem_req", 32'(bus.imem_req), 32'(!bus.branch && !es));
    checkVal("imem_addr", 32'(bus.imem_addr), 32'(bus.pc_addr));
    checkVal("instr_valid", 32'(bus.instr_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkVal("instr", 32'(bus.instr), 32'(model_q[0].instr));
      checkVal("instr_pc", 32'(bus.instr_pc), 32'(model_q[0].pc));
    end
  endtask

  // One clock cycle: drive inputs, check, take the edge, advance model and PC.
  task automatic applyStimulus(input logic br, input logic dr, input logic [AW-1:0] tgt);
    logic          es;
    logic          req;
    logic [AW-1:0] pc_next;
    bus.branch    = br;
    bus.dec_ready = dr;
    #1;
    checkOutput();
    es      = model_stall();
    req     = !br && !es;
    pc_next = br ? tgt : (req ? AW'(bus.pc_addr + 1'b1) : bus.pc_addr);
    @(posedge clk);
    if (br) begin
      model_q.delete();
      pend = 1'b0;
    end else begin
      if (model_q.size() != 0 && dr) void'(model_q.pop_front());
      if (pend) model_q.push_back('{instr: mem_word(pend_addr), pc: pend_addr});
      pend      = req;
      pend_addr = bus.pc_addr;
    end
    #1;
    bus.pc_addr = pc_next;
  endtask

  initial begin
    reset          = 1'b1;
    bus.pc_addr    = '0;
    bus.branch     = 1'b0;
    bus.dec_ready  = 1'b0;
    resetModel();
    #12;
    checkVal("rst_valid", 32'(bus.instr_valid), 32'd0);
    checkVal("rst_stall", 32'(bus.stall), 32'd0);
    checkVal("rst_req", 32'(bus.imem_req), 32'd1);
    reset = 1'b0;

    // Streaming from address 0 with decode always ready.
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("stream_valid", 32'(bus.instr_valid), 32'd1);
    checkVal("stream_i0", 32'(bus.instr), 32'h1000);
    checkVal("stream_pc0", 32'(bus.instr_pc), 32'h0);
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("stream_i1", 32'(bus.instr), 32'h1001);
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("stream_i2", 32'(bus.instr), 32'h1002);
    checkVal("stream_pc2", 32'(bus.instr_pc), 32'h2);

    // Refill from 0 with decode stalled until the queue is full.
    applyStimulus(1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0);
    checkVal("full_stall", 32'(bus.stall), 32'd1);
    checkVal("full_req", 32'(bus.imem_req), 32'd0);
    checkVal("full_head", 32'(bus.instr), 32'h1000);
    checkVal("full_head_pc", 32'(bus.instr_pc), 32'h0);

    // Drain: stall must drop right after the first pop.
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("drain_stall", 32'(bus.stall), 32'd0);
    checkVal("drain_head", 32'(bus.instr), 32'h1001);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, '0);

    // Build up three queued plus one in flight, then branch to 0x200.
    for (int i = 0; i < 8; i++) begin
      if (model_q.size() == 3 && pend) break;
      applyStimulus(1'b0, 1'b0, '0);
    end
    checkVal("flush_setup_stall", 32'(bus.stall), 32'd1);
    applyStimulus(1'b1, 1'b1, 10'h200);
    checkVal("flush_valid", 32'(bus.instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("flush_instr", 32'(bus.instr), 32'h1200);
    checkVal("flush_pc", 32'(bus.instr_pc), 32'h200);

    // Back-to-back branches: only the last target may be delivered.
    applyStimulus(1'b1, 1'b1, 10'h300);
    applyStimulus(1'b1, 1'b1, 10'h3F0);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("b2b_pc", 32'(bus.instr_pc), 32'h3F0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0);

    // Asynchronous reset pulse between edges while streaming.
    applyStimulus(1'b0, 1'b0, '0);
    #2;
    reset = 1'b1;
    #1;
    checkVal("async_valid", 32'(bus.instr_valid), 32'd0);
    checkVal("async_stall", 32'(bus.stall), 32'd0);
    resetModel();
    bus.pc_addr = 10'h150;
    @(posedge clk);
    #3;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkVal("post_rst_valid", 32'(bus.instr_valid), 32'd1);
    checkVal("post_rst_pc", 32'(bus.instr_pc), 32'h150);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      logic          br;
      logic          dr;
      logic [AW-1:0] tgt;
      br  = ($urandom_range(0, 15) == 0);
      dr  = ($urandom_range(0, 3) != 0);
      tgt = AW'($urandom);
      applyStimulus(br, dr, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
